ramen_shop: RTL and testbench
=============================

RAMEN_SHOP -- requirements
Module: ramen_shop

Interface
REQ-001 SHALL have parameter CNT_W, default 7, width of each per-type sold counter.
REQ-002 SHALL have parameter STOCK_W, default 16, width of every stock register.
REQ-003 SHALL have parameters NOODLE_INIT 12000, BROTH_INIT 41000, TONK_INIT 9000, MISO_INIT 1000, SOY_INIT 1500, giving the stock reload values.
REQ-004 SHALL have one clock; reset is asynchronous and active-low, with ports named as follows.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following order and restock inputs.
- in_valid  in  1  transaction strobe.
- cmd  in  1  transaction kind: 0 = order, 1 = restock.
- ramen_type  in  2  order type: 0 tonkotsu, 1 tonkotsu-soy, 2 miso, 3 miso-soy.
- portion  in  1  0 = small, 1 = large.
- item  in  3  restock target: 0 noodle, 1 broth, 2 tonkotsu soup, 3 miso, 4 soy; 5-7 are reserved.
- amount  in  STOCK_W  restock quantity.
REQ-006 SHALL have the following session input.
- selling  in  1  session-open level.
REQ-007 SHALL have the following order outputs.
- out_valid_order  out  1  one-cycle order-result strobe.
- success  out  1  order accepted; valid only with out_valid_order.
REQ-008 SHALL have the following summary outputs.
- out_valid_tot  out  1  one-cycle session-summary strobe.
- sold_num  out  4*CNT_W  counts {type0, type1, type2, type3}, type0 in the MSBs.
- total_gain  out  CNT_W+10  session revenue.

Function
REQ-009 SHALL present an order as in_valid high for exactly 2 consecutive cycles.
- Cycle 1 carries cmd=0 and ramen_type.
- Cycle 2 carries portion.
REQ-010 SHALL present a restock as in_valid high for exactly 1 cycle with cmd=1, item and amount.
REQ-011 SHALL guarantee at least 1 idle cycle between transactions; behaviour under any other in_valid pattern is undefined.
REQ-012 SHALL implement states IDLE, ORD_IN, ORD_RES and SUM, with these transitions:
- IDLE -> ORD_IN on in_valid & !cmd.
- ORD_IN -> ORD_RES when in_valid falls.
- ORD_RES -> IDLE if selling=1.
- ORD_RES -> SUM if selling=0.
- SUM -> IDLE unconditionally.
REQ-013 SHALL use this recipe table, given as noodle/broth/tonk/soy/miso, small ; large.
- Type 0: 100/300/150/0/0 ; 150/500/200/0/0.
- Type 1: 100/300/100/30/0 ; 150/500/150/50/0.
- Type 2: 100/400/0/0/30 ; 150/650/0/0/50.
- Type 3: 100/300/70/15/15 ; 150/500/100/25/25.
REQ-014 SHALL accept an order only if every stock is >= its recipe requirement.
- Accepted: deduct all five requirements at the ORD_RES entry edge, and increment that type's counter.
- Rejected: change no stock and no counter.
REQ-015 SHALL drive out_valid_order=1 for exactly one cycle, in the cycle after in_valid falls for an order (latency 1), with success valid in that cycle.
REQ-016 SHALL hold out_valid_order=0 and success=0 in every other cycle.
REQ-017 SHALL saturate each sold counter at 2^CNT_W-1; an accepted order at saturation still deducts stock and still reports success=1.
REQ-018 SHALL apply a restock on the edge ending its in_valid cycle: stock[item] = min(stock[item]+amount, 2^STOCK_W-1).
REQ-019 SHALL make a restock produce no output pulse, and SHALL ignore reserved item codes.
REQ-020 SHALL detect a session start as the rising edge of selling, using a registered copy of selling that resets to 0.
- On session start: reload all stocks to *_INIT and clear all counters.
- If a restock occurs in the same cycle, the reload wins.
REQ-021 SHALL, in the SUM cycle (the cycle after ORD_RES), drive out_valid_tot=1 together with:
- sold_num = the four counters, including the order just reported.
- total_gain = 200*(c0+c2) + 250*(c1+c3), computed without overflow at CNT_W+10 bits.
REQ-022 SHALL hold sold_num=0 and total_gain=0 whenever out_valid_tot=0.
REQ-023 SHALL, at the edge leaving SUM, clear all counters and reload all stocks to *_INIT.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force:
- all outputs to 0;
- the state to IDLE;
- the registered selling copy to 0;
- all counters and all stocks to 0.
REQ-025 SHALL abandon any order in progress when reset occurs mid-order, producing no result pulse after rst_n rises.

Verification
REQ-026 SHALL cover: selling rises, then a type-2 large order -> out_valid_order=1 and success=1 one cycle after in_valid falls; miso stock 950, broth 40350.
REQ-027 SHALL cover: 20 type-2 large orders, then a 21st -> the 21st reports success=0 (miso is 0), and no stock changes.
REQ-028 SHALL cover: restock item 3 with amount 500 after miso is exhausted -> the next type-2 small order reports success=1 and miso becomes 470.
REQ-029 SHALL cover: orders of type0 x2, type1 x1, type3 x1 with selling falling before the last result -> out_valid_tot one cycle after that result; sold_num fields 2/1/0/1; total_gain 900.
REQ-030 SHALL cover: CNT_W=2 with 5 accepted type-0 orders, then close -> type0 field = 3 and total_gain = 600.
REQ-031 SHALL cover: restock of item 0 with amount 0xFFFF -> noodle = 65535 (saturated); reset asserted during the order's second cycle -> no out_valid_order pulse and all outputs 0.

Source files
------------

// File: rtl/ramen_shop.sv
// Ramen shop order/restock controller: stock bookkeeping, per-type sales counters
// and an end-of-session summary.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an order; restocks are applied from here
// ORD_IN  | order in progress; portion captured while in_valid is high
// ORD_RES | order result presented on out_valid_order/success
// SUM     | session summary presented on out_valid_tot
module ramen_shop #(
   parameter int CNT_W       = 7,
   parameter int STOCK_W     = 16,
   parameter int NOODLE_INIT = 12000,
   parameter int BROTH_INIT  = 41000,
   parameter int TONK_INIT   = 9000,
   parameter int MISO_INIT   = 1000,
   parameter int SOY_INIT    = 1500
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic                 cmd,
   input  logic [1:0]           ramen_type,
   input  logic                 portion,
   input  logic [2:0]           item,
   input  logic [STOCK_W-1:0]   amount,
   input  logic                 selling,
   output logic                 out_valid_order,
   output logic                 success,
   output logic                 out_valid_tot,
   output logic [4*CNT_W-1:0]   sold_num,
   output logic [CNT_W+9:0]     total_gain
);

   localparam int GW = CNT_W + 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ORD_IN  = 2'd1,
      ORD_RES = 2'd2,
      SUM     = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Stock index matches the restock item code.
   logic [STOCK_W-1:0] stock [5];
   logic [CNT_W-1:0]   cnt [4];
   logic [1:0]         type_q;
   logic               portion_q;
   logic               ok_q;
   logic               sell_q;

   logic [9:0]         req [5];
   logic               enough;
   logic               ord_done;
   logic               restock;
   logic               reload;
   logic [STOCK_W:0]   rs_sum [5];
   logic [STOCK_W-1:0] init_val [5];

   always_comb begin
      init_val[0] = STOCK_W'(NOODLE_INIT);
      init_val[1] = STOCK_W'(BROTH_INIT);
      init_val[2] = STOCK_W'(TONK_INIT);
      init_val[3] = STOCK_W'(MISO_INIT);
      init_val[4] = STOCK_W'(SOY_INIT);
   end

   // Recipe requirements in stock order: noodle, broth, tonkotsu, miso, soy.
   always_comb begin
      req[0] = portion_q ? 10'd150 : 10'd100;
      req[1] = 10'd0;
      req[2] = 10'd0;
      req[3] = 10'd0;
      req[4] = 10'd0;
      case (type_q)
         2'd0: begin
            req[1] = portion_q ? 10'd500 : 10'd300;
            req[2] = portion_q ? 10'd200 : 10'd150;
         end
         2'd1: begin
            req[1] = portion_q ? 10'd500 : 10'd300;
            req[2] = portion_q ? 10'd150 : 10'd100;
            req[4] = portion_q ? 10'd50  : 10'd30;
         end
         2'd2: begin
            req[1] = portion_q ? 10'd650 : 10'd400;
            req[3] = portion_q ? 10'd50  : 10'd30;
         end
         default: begin
            req[1] = portion_q ? 10'd500 : 10'd300;
            req[2] = portion_q ? 10'd100 : 10'd70;
            req[3] = portion_q ? 10'd25  : 10'd15;
            req[4] = portion_q ? 10'd25  : 10'd15;
         end
      endcase
   end

   always_comb begin
      enough = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (stock[i] < STOCK_W'(req[i])) enough = 1'b0;
         rs_sum[i] = {1'b0, stock[i]} + {1'b0, amount};
      end
   end

   assign ord_done = (state_q == ORD_IN) && !in_valid;
   // The second cycle of an order has cmd undefined, so restocks are ignored in ORD_IN.
   assign restock  = in_valid && cmd && (state_q != ORD_IN);
   assign reload   = (selling && !sell_q) || (state_q == SUM);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid && !cmd) state_d = ORD_IN;
         ORD_IN:  if (!in_valid)        state_d = ORD_RES;
         ORD_RES: state_d = selling ? IDLE : SUM;
         SUM:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sell_q    <= 1'b0;
         type_q    <= 2'd0;
         portion_q <= 1'b0;
         ok_q      <= 1'b0;
         for (int i = 0; i < 5; i++) stock[i] <= '0;
         for (int j = 0; j < 4; j++) cnt[j] <= '0;
      end else begin
         state_q <= state_d;
         sell_q  <= selling;
         if ((state_q == IDLE) && in_valid && !cmd) type_q <= ramen_type;
         if ((state_q == ORD_IN) && in_valid) portion_q <= portion;
         if (ord_done) ok_q <= enough;
         // Session start and summary exit both reload, overriding any concurrent update.
         if (reload) begin
            for (int i = 0; i < 5; i++) stock[i] <= init_val[i];
            for (int j = 0; j < 4; j++) cnt[j] <= '0;
         end else if (ord_done && enough) begin
            for (int i = 0; i < 5; i++) stock[i] <= stock[i] - STOCK_W'(req[i]);
            for (int j = 0; j < 4; j++)
               if ((type_q == 2'(j)) && (cnt[j] != '1)) cnt[j] <= cnt[j] + 1'b1;
         end else if (restock) begin
            for (int i = 0; i < 5; i++)
               if (item == 3'(i))
                  stock[i] <= rs_sum[i][STOCK_W] ? '1 : rs_sum[i][STOCK_W-1:0];
         end
      end
   end

   always_comb begin
      out_valid_order = (state_q == ORD_RES);
      success         = (state_q == ORD_RES) && ok_q;
      out_valid_tot   = (state_q == SUM);
      sold_num        = '0;
      total_gain      = '0;
      if (state_q == SUM) begin
         sold_num   = {cnt[0], cnt[1], cnt[2], cnt[3]};
         total_gain = GW'(200) * (GW'(cnt[0]) + GW'(cnt[2]))
                    + GW'(250) * (GW'(cnt[1]) + GW'(cnt[3]));
      end
   end

endmodule

// File: tb/tb_ramen_shop.sv
// Bench for ramen_shop: directed scenarios followed by random orders/restocks,
// checked against a recipe-table model of stocks, counters and session summaries.
module tb_ramen_shop;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        cmd = 1'b0;
   logic [1:0]  ramen_type = 2'd0;
   logic        portion = 1'b0;
   logic [2:0]  item = 3'd0;
   logic [15:0] amount = 16'd0;
   logic        selling = 1'b0;

   logic        ovo, succ, ovt;
   logic [27:0] sold;
   logic [16:0] gain;
   logic        ovo2, succ2, ovt2;
   logic [7:0]  sold2;
   logic [11:0] gain2;

   ramen_shop dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cmd(cmd), .ramen_type(ramen_type),
      .portion(portion), .item(item), .amount(amount), .selling(selling),
      .out_valid_order(ovo), .success(succ), .out_valid_tot(ovt),
      .sold_num(sold), .total_gain(gain));

   ramen_shop #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cmd(cmd), .ramen_type(ramen_type),
      .portion(portion), .item(item), .amount(amount), .selling(selling),
      .out_valid_order(ovo2), .success(succ2), .out_valid_tot(ovt2),
      .sold_num(sold2), .total_gain(gain2));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state; stock order noodle, broth, tonkotsu, miso, soy.
   int m_stock [5];
   int m_cnt [4];
   bit m_sellq;
   int init_v [5] = '{12000, 41000, 9000, 1000, 1500};
   int rq [4][2][5] = '{
      '{'{100, 300, 150,  0,  0}, '{150, 500, 200,  0,  0}},
      '{'{100, 300, 100,  0, 30}, '{150, 500, 150,  0, 50}},
      '{'{100, 400,   0, 30,  0}, '{150, 650,   0, 50,  0}},
      '{'{100, 300,  70, 15, 15}, '{150, 500, 100, 25, 25}}};

   logic [63:0] last_sold, last_sold2, last_gain, last_gain2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic reload_model();
      for (int i = 0; i < 5; i++) m_stock[i] = init_v[i];
      for (int j = 0; j < 4; j++) m_cnt[j] = 0;
   endtask

   // Pending model updates for this edge must be applied before calling tick,
   // so a session-start reload here overrides them.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         if (selling && !m_sellq) reload_model();
         m_sellq = selling;
      end
      #1;
   endtask

   function automatic logic [63:0] exp_sold(input int w);
      logic [63:0] r = 0;
      for (int j = 0; j < 4; j++) begin
         int c = (m_cnt[j] > (1 << w) - 1) ? (1 << w) - 1 : m_cnt[j];
         r = (r << w) | 64'(c);
      end
      return r;
   endfunction

   function automatic logic [63:0] exp_gain(input int w);
      int c [4];
      for (int j = 0; j < 4; j++) c[j] = (m_cnt[j] > (1 << w) - 1) ? (1 << w) - 1 : m_cnt[j];
      return 64'(200 * (c[0] + c[2]) + 250 * (c[1] + c[3]));
   endfunction

   task automatic check_stocks();
      for (int i = 0; i < 5; i++) chk($sformatf("stock%0d", i), 64'(dut.stock[i]), 64'(m_stock[i]));
   endtask

   task automatic do_order(input int t, input bit p, input bit close);
      bit ok = 1'b1;
      in_valid = 1'b1; cmd = 1'b0; ramen_type = 2'(t); portion = 1'($urandom);
      tick();
      chk("ovo_in1", 64'(ovo), 0);
      portion = p; cmd = 1'($urandom); ramen_type = 2'($urandom);
      tick();
      chk("ovo_in2", 64'(ovo), 0);
      in_valid = 1'b0; cmd = 1'b0;
      if (close) selling = 1'b0;
      for (int i = 0; i < 5; i++) if (m_stock[i] < rq[t][p][i]) ok = 1'b0;
      if (ok) begin
         for (int i = 0; i < 5; i++) m_stock[i] -= rq[t][p][i];
         m_cnt[t]++;
      end
      tick();
      chk("ovo_res", 64'(ovo), 1);
      chk("success", 64'(succ), 64'(ok));
      chk("success2", 64'(succ2), 64'(ok));
      chk("ovt_res", 64'(ovt), 0);
      if (!selling) begin
         tick();
         chk("ovt_sum", 64'(ovt), 1);
         chk("ovo_sum", 64'(ovo), 0);
         chk("sold_num", 64'(sold), exp_sold(7));
         chk("total_gain", 64'(gain), exp_gain(7));
         chk("sold_num2", 64'(sold2), exp_sold(2));
         chk("total_gain2", 64'(gain2), exp_gain(2));
         last_sold = 64'(sold); last_gain = 64'(gain);
         last_sold2 = 64'(sold2); last_gain2 = 64'(gain2);
         reload_model();
         tick();
         chk("ovt_after", 64'(ovt), 0);
         chk("sold_idle", 64'(sold), 0);
         chk("gain_idle", 64'(gain), 0);
      end else begin
         tick();
         chk("ovo_after", 64'(ovo), 0);
         chk("ovt_none", 64'(ovt), 0);
      end
      check_stocks();
   endtask

   task automatic do_restock(input int it, input int amt);
      in_valid = 1'b1; cmd = 1'b1; item = 3'(it); amount = 16'(amt);
      if (it < 5) m_stock[it] = (m_stock[it] + amt > 65535) ? 65535 : m_stock[it] + amt;
      tick();
      in_valid = 1'b0; cmd = 1'b0;
      chk("ovo_rst", 64'(ovo), 0);
      chk("ovt_rst", 64'(ovt), 0);
      tick();
      check_stocks();
   endtask

   task automatic set_sell(input bit v);
      selling = v;
      tick();
   endtask

   initial begin
      for (int i = 0; i < 5; i++) m_stock[i] = 0;
      for (int j = 0; j < 4; j++) m_cnt[j] = 0;
      m_sellq = 1'b0;
      last_sold = 0; last_sold2 = 0; last_gain = 0; last_gain2 = 0;

      tick(); tick();
      chk("rst_ovo", 64'(ovo), 0);
      chk("rst_succ", 64'(succ), 0);
      chk("rst_ovt", 64'(ovt), 0);
      chk("rst_sold", 64'(sold), 0);
      chk("rst_gain", 64'(gain), 0);
      check_stocks();
      rst_n = 1'b1;
      tick();

      // Open, one type-2 large order.
      set_sell(1'b1);
      do_order(2, 1'b1, 1'b0);
      chk("miso_950", 64'(dut.stock[3]), 950);
      chk("broth_40350", 64'(dut.stock[1]), 40350);

      // Exhaust miso, then a rejected order.
      for (int k = 0; k < 19; k++) do_order(2, 1'b1, 1'b0);
      chk("miso_0", 64'(dut.stock[3]), 0);
      do_order(2, 1'b1, 1'b0);
      chk("miso_still_0", 64'(dut.stock[3]), 0);
      chk("broth_28000", 64'(dut.stock[1]), 28000);

      // Restock miso, then a small type-2 order.
      do_restock(3, 500);
      do_order(2, 1'b0, 1'b0);
      chk("miso_470", 64'(dut.stock[3]), 470);

      // New session with a mixed batch, closed during the last order.
      set_sell(1'b0);
      set_sell(1'b1);
      do_order(0, 1'b0, 1'b0);
      do_order(0, 1'b1, 1'b0);
      do_order(1, 1'b0, 1'b0);
      do_order(3, 1'b1, 1'b1);
      chk("sold_2101", last_sold, {36'd0, 7'd2, 7'd1, 7'd0, 7'd1});
      chk("gain_900", last_gain, 900);

      // Counter saturation on the narrow instance.
      set_sell(1'b1);
      for (int k = 0; k < 5; k++) do_order(0, 1'b0, k == 4);
      chk("sat_type0", 64'(last_sold2[7:6]), 3);
      chk("sat_gain", last_gain2, 600);
      chk("wide_gain", last_gain, 1000);

      // Session start on the same edge as a restock: reload wins.
      selling = 1'b1;
      do_restock(0, 5);
      chk("reload_wins", 64'(dut.stock[0]), 12000);

      do_restock(0, 16'hFFFF);
      chk("noodle_sat", 64'(dut.stock[0]), 65535);

      // Reset during the second cycle of an order.
      in_valid = 1'b1; cmd = 1'b0; ramen_type = 2'd2;
      tick();
      portion = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_ovo", 64'(ovo), 0);
      chk("mid_rst_succ", 64'(succ), 0);
      chk("mid_rst_ovt", 64'(ovt), 0);
      chk("mid_rst_sold", 64'(sold), 0);
      chk("mid_rst_gain", 64'(gain), 0);
      for (int i = 0; i < 5; i++) m_stock[i] = 0;
      for (int j = 0; j < 4; j++) m_cnt[j] = 0;
      m_sellq = 1'b0;
      check_stocks();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("no_pulse", 64'(ovo), 0);
      end
      check_stocks();

      // Random traffic.
      for (int n = 0; n < 150; n++) begin
         int r = $urandom_range(0, 9);
         if (r <= 5)
            do_order($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 7) == 0);
         else if (r <= 7)
            do_restock($urandom_range(0, 7),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                                   : int'($urandom_range(0, 2000)));
         else if (r == 8)
            set_sell(!selling);
         else
            set_sell(1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
